// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the program-counter sequencer.
// - op_e: one operation selected per cycle from the control-unit strobes.
// - Strb*: bit positions of the strobe vector handed to decode_op.
// - decode_op: fixed-priority encoder CLR > INTR > RET > CALL > LD > SKIP > INC.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_INC,
    OP_SKIP,
    OP_LD,
    OP_CALL,
    OP_RET,
    OP_INTR,
    OP_CLR
  } op_e;

  localparam int unsigned StrbInc  = 0;
  localparam int unsigned StrbSkip = 1;
  localparam int unsigned StrbLd   = 2;
  localparam int unsigned StrbCall = 3;
  localparam int unsigned StrbRet  = 4;
  localparam int unsigned StrbIntr = 5;
  localparam int unsigned StrbClr  = 6;

  // Only the highest-priority strobe survives; the rest are ignored entirely.
  function automatic op_e decode_op(input logic [6:0] strb);
    if (strb[StrbClr])       return OP_CLR;
    else if (strb[StrbIntr]) return OP_INTR;
    else if (strb[StrbRet])  return OP_RET;
    else if (strb[StrbCall]) return OP_CALL;
    else if (strb[StrbLd])   return OP_LD;
    else if (strb[StrbSkip]) return OP_SKIP;
    else if (strb[StrbInc])  return OP_INC;
    else                     return OP_NONE;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-unit <-> program-counter bundle.
// - master: control unit; drives op strobes, err_clr and data; observes the PC and stack status.
// - slave:  pc_sequencer; the reverse.
// Signals: clr, inc, skip, ld, call, ret, intr, err_clr (strobes), data (W-bit target),
//          q (registered PC), sp (0..DEPTH), stk_empty, stk_full, stk_err (sticky).
interface pc_sequencer_if #(
  parameter int unsigned W     = 12,
  parameter int unsigned DEPTH = 4
);

  logic                     clr;
  logic                     inc;
  logic                     skip;
  logic                     ld;
  logic                     call;
  logic                     ret;
  logic                     intr;
  logic                     err_clr;
  logic [W-1:0]             data;
  logic [W-1:0]             q;
  logic [$clog2(DEPTH):0]   sp;
  logic                     stk_empty;
  logic                     stk_full;
  logic                     stk_err;

  modport master (
    output clr, inc, skip, ld, call, ret, intr, err_clr, data,
    input  q, sp, stk_empty, stk_full, stk_err
  );

  modport slave (
    input  clr, inc, skip, ld, call, ret, intr, err_clr, data,
    output q, sp, stk_empty, stk_full, stk_err
  );

endinterface

// File: rtl/pc_ret_stack.sv
// Return-address LIFO for the program counter.
// Ports: clk, rst_n (async active-low, clears sp only), push/pop/flush strobes,
//        push_data (W), sp (0..DEPTH), top (entry at sp-1), full, empty.
// flush beats push beats pop; push when full and pop when empty are ignored.
module pc_ret_stack #(
  parameter int unsigned W     = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           push_data,
  output logic [$clog2(DEPTH):0] sp,
  output logic [W-1:0]           top,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] SpFull = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   sp_q, sp_d;
  logic [AW-1:0] top_idx;
  logic          do_push;

  assign full    = (sp_q == SpFull);
  assign empty   = (sp_q == '0);
  assign do_push = push && !full && !flush;

  always_comb begin
    sp_d = sp_q;
    if (flush) begin
      sp_d = '0;
    end else if (do_push) begin
      sp_d = sp_q + (AW + 1)'(1);
    end else if (pop && !empty) begin
      sp_d = sp_q - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Storage is deliberately unreset: entries at or above sp are never read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[sp_q[AW-1:0]] <= push_data;
    end
  end

  // Wraps to DEPTH-1 when sp is DEPTH (low bits zero); meaningless when empty.
  assign top_idx = sp_q[AW-1:0] - AW'(1);
  assign top     = mem[top_idx];
  assign sp      = sp_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with skip, call/return via a hardware return stack, and interrupt vectoring.
// Ports: clk, rst_n (async active-low), bus (pc_sequencer_if.slave): op strobes and data in,
//        registered PC q, stack pointer sp, stk_empty/stk_full, sticky stk_err out.
// One op per cycle by fixed priority; every effect lands on the next rising edge.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned W         = 12,
  parameter int unsigned DEPTH     = 4,
  parameter logic [W-1:0] RESET_VEC = '0,
  parameter logic [W-1:0] INT_VEC   = {{(W-1){1'b0}}, 1'b1}
) (
  input logic            clk,
  input logic            rst_n,
  pc_sequencer_if.slave  bus
);

  op_e          op;
  logic [W-1:0] q_q, q_d;
  logic         err_q, err_d;
  logic         err_set;
  logic         push, pop, flush;
  logic [W-1:0] push_data;
  logic [W-1:0] top;
  logic         full, empty;
  logic [W-1:0] q_inc;

  assign op    = decode_op({bus.clr, bus.intr, bus.ret, bus.call, bus.ld, bus.skip, bus.inc});
  assign q_inc = q_q + W'(1);

  pc_ret_stack #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data (push_data),
    .sp        (bus.sp),
    .top       (top),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    q_d       = q_q;
    push      = 1'b0;
    pop       = 1'b0;
    flush     = 1'b0;
    push_data = q_inc;
    err_set   = 1'b0;
    unique case (op)
      OP_CLR: begin
        q_d   = RESET_VEC;
        flush = 1'b1;
      end
      OP_INTR: begin
        // Interrupted instruction has not executed yet, so save the PC unincremented.
        q_d       = INT_VEC;
        push      = !full;
        push_data = q_q;
        err_set   = full;
      end
      OP_RET: begin
        if (empty) begin
          // Underflow degrades to a plain increment so fetch keeps moving.
          q_d     = q_inc;
          err_set = 1'b1;
        end else begin
          q_d = top;
          pop = 1'b1;
        end
      end
      OP_CALL: begin
        // Jump happens even on overflow; only the return address is lost.
        q_d     = bus.data;
        push    = !full;
        err_set = full;
      end
      OP_LD:   q_d = bus.data;
      OP_SKIP: q_d = q_q + W'(2);
      OP_INC:  q_d = q_inc;
      OP_NONE: q_d = q_q;
      default: q_d = q_q;
    endcase
  end

  // A new error in the same cycle as err_clr must not be lost.
  always_comb begin
    err_d = err_q;
    if (err_set) begin
      err_d = 1'b1;
    end else if (bus.err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= RESET_VEC;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
    end
  end

  assign bus.q         = q_q;
  assign bus.stk_err   = err_q;
  assign bus.stk_empty = empty;
  assign bus.stk_full  = full;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer (W=12, DEPTH=4, RESET_VEC=0, INT_VEC=1).
// Stimulus drives one op per cycle at the falling edge and queues the hand-computed state
// expected after the next rising edge; a monitor pops and compares 1 time unit after each edge.
module tb_pc_sequencer;

  localparam logic [6:0] S_NONE = 7'b0000000;
  localparam logic [6:0] S_INC  = 7'b0000001;
  localparam logic [6:0] S_SKIP = 7'b0000010;
  localparam logic [6:0] S_LD   = 7'b0000100;
  localparam logic [6:0] S_CALL = 7'b0001000;
  localparam logic [6:0] S_RET  = 7'b0010000;
  localparam logic [6:0] S_INTR = 7'b0100000;
  localparam logic [6:0] S_CLR  = 7'b1000000;

  typedef struct {
    string       nm;
    logic [11:0] q;
    logic [2:0]  sp;
    logic        err;
    int          due;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  pc_sequencer_if #(.W(12), .DEPTH(4)) bus ();

  pc_sequencer #(
    .W         (12),
    .DEPTH     (4),
    .RESET_VEC (12'h000),
    .INT_VEC   (12'h001)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input logic [11:0] eq, input logic [2:0] esp,
                           input logic eerr);
    cmp(nm, "q", 32'(bus.q), 32'(eq));
    cmp(nm, "sp", 32'(bus.sp), 32'(esp));
    cmp(nm, "stk_err", 32'(bus.stk_err), 32'(eerr));
    cmp(nm, "stk_full", 32'(bus.stk_full), 32'(esp == 3'd4));
    cmp(nm, "stk_empty", 32'(bus.stk_empty), 32'(esp == 3'd0));
  endtask

  task automatic drive(input logic [6:0] s, input logic eclr, input logic [11:0] d);
    {bus.clr, bus.intr, bus.ret, bus.call, bus.ld, bus.skip, bus.inc} = s;
    bus.err_clr = eclr;
    bus.data    = d;
  endtask

  // One op per call: drive on the falling edge, expectation due at the following rising edge.
  task automatic step(input string nm, input logic [6:0] s, input logic eclr,
                      input logic [11:0] d, input logic [11:0] eq, input logic [2:0] esp,
                      input logic eerr);
    exp_t e;
    @(negedge clk);
    drive(s, eclr, d);
    e.nm  = nm;
    e.q   = eq;
    e.sp  = esp;
    e.err = eerr;
    e.due = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #2;
    drive(S_NONE, 1'b0, 12'h000);
  endtask

  // Monitor: compare any queued expectation that falls due on this edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        check_all(e.nm, e.q, e.sp, e.err);
      end
    end
  end

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    drive(S_NONE, 1'b0, 12'h000);
    rst_n = 1'b0;
    #12;
    check_all("reset", 12'h000, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Increment and wrap
    for (int i = 1; i <= 5; i++) step("inc", S_INC, 1'b0, 12'h000, 12'(i), 3'd0, 1'b0);
    step("ld_fff", S_LD, 1'b0, 12'hFFF, 12'hFFF, 3'd0, 1'b0);
    step("inc_wrap", S_INC, 1'b0, 12'h000, 12'h000, 3'd0, 1'b0);

    // Priority
    step("ld_010", S_LD, 1'b0, 12'h010, 12'h010, 3'd0, 1'b0);
    step("prio_ld", S_INC | S_LD | S_SKIP, 1'b0, 12'h2A0, 12'h2A0, 3'd0, 1'b0);
    step("prio_clr", S_CLR | S_INTR, 1'b0, 12'h000, 12'h000, 3'd0, 1'b0);
    step("hold", S_NONE, 1'b0, 12'h123, 12'h000, 3'd0, 1'b0);

    // Nested call/return
    step("ld_100", S_LD, 1'b0, 12'h100, 12'h100, 3'd0, 1'b0);
    step("call_200", S_CALL, 1'b0, 12'h200, 12'h200, 3'd1, 1'b0);
    step("call_300", S_CALL, 1'b0, 12'h300, 12'h300, 3'd2, 1'b0);
    step("ret_201", S_RET, 1'b0, 12'h000, 12'h201, 3'd1, 1'b0);
    step("ret_101", S_RET, 1'b0, 12'h000, 12'h101, 3'd0, 1'b0);

    // Overflow, then LIFO unwind
    step("call_400", S_CALL, 1'b0, 12'h400, 12'h400, 3'd1, 1'b0);
    step("call_500", S_CALL, 1'b0, 12'h500, 12'h500, 3'd2, 1'b0);
    step("call_600", S_CALL, 1'b0, 12'h600, 12'h600, 3'd3, 1'b0);
    step("call_700", S_CALL, 1'b0, 12'h700, 12'h700, 3'd4, 1'b0);
    step("call_ovf", S_CALL, 1'b0, 12'h555, 12'h555, 3'd4, 1'b1);
    step("ret_601", S_RET, 1'b0, 12'h000, 12'h601, 3'd3, 1'b1);
    step("ret_501", S_RET, 1'b0, 12'h000, 12'h501, 3'd2, 1'b1);
    step("ret_401", S_RET, 1'b0, 12'h000, 12'h401, 3'd1, 1'b1);
    step("ret_102", S_RET, 1'b0, 12'h000, 12'h102, 3'd0, 1'b1);

    // Underflow and err_clr
    step("errclr0", S_NONE, 1'b1, 12'h000, 12'h102, 3'd0, 1'b0);
    step("ld_07f", S_LD, 1'b0, 12'h07F, 12'h07F, 3'd0, 1'b0);
    step("ret_udf", S_RET, 1'b0, 12'h000, 12'h080, 3'd0, 1'b1);
    step("errclr1", S_NONE, 1'b1, 12'h000, 12'h080, 3'd0, 1'b0);
    step("udf_vs_clr", S_RET, 1'b1, 12'h000, 12'h081, 3'd0, 1'b1);
    step("errclr2", S_NONE, 1'b1, 12'h000, 12'h081, 3'd0, 1'b0);

    // Skip wrap
    step("ld_ffe", S_LD, 1'b0, 12'hFFE, 12'hFFE, 3'd0, 1'b0);
    step("skip_ffe", S_SKIP, 1'b0, 12'h000, 12'h000, 3'd0, 1'b0);
    step("ld_fff2", S_LD, 1'b0, 12'hFFF, 12'hFFF, 3'd0, 1'b0);
    step("skip_fff", S_SKIP, 1'b0, 12'h000, 12'h001, 3'd0, 1'b0);

    // CLR flushes the stack but leaves stk_err alone
    step("call_050", S_CALL, 1'b0, 12'h050, 12'h050, 3'd1, 1'b0);
    step("clr_flush", S_CLR, 1'b0, 12'h000, 12'h000, 3'd0, 1'b0);
    step("ret_aftclr", S_RET, 1'b0, 12'h000, 12'h001, 3'd0, 1'b1);
    step("clr_err", S_CLR, 1'b0, 12'h000, 12'h000, 3'd0, 1'b1);
    step("errclr3", S_NONE, 1'b1, 12'h000, 12'h000, 3'd0, 1'b0);

    // Interrupt
    step("ld_0a5", S_LD, 1'b0, 12'h0A5, 12'h0A5, 3'd0, 1'b0);
    step("intr", S_INTR, 1'b0, 12'h000, 12'h001, 3'd1, 1'b0);
    step("ret_intr", S_RET, 1'b0, 12'h000, 12'h0A5, 3'd0, 1'b0);

    // Build up some state, then async reset between edges
    step("ld_123", S_LD, 1'b0, 12'h123, 12'h123, 3'd0, 1'b0);
    step("call_a", S_CALL, 1'b0, 12'h200, 12'h200, 3'd1, 1'b0);
    step("ret_a", S_RET, 1'b0, 12'h000, 12'h124, 3'd0, 1'b0);
    step("ret_udf2", S_RET, 1'b0, 12'h000, 12'h125, 3'd0, 1'b1);
    step("call_b", S_CALL, 1'b0, 12'h300, 12'h300, 3'd1, 1'b1);

    // Queue must drain before the asynchronous check
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
      sb.delete();
    end

    #1;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 12'h000, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step("inc_post", S_INC, 1'b0, 12'h000, 12'h001, 3'd0, 1'b0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_end: got %0d pending, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program counter for the Mano-style CPU datapath; generalises the 4-bit PC to W-bit addresses.
- Adds skip (+2), subroutine call/return through a hardware return-address stack, and an interrupt vector jump.
- Sits between the control unit (one-hot op strobes) and the memory address path.
- Drives the registered fetch address Q every cycle.

Parameters:
- W, 12, address width in bits.
- DEPTH, 4, return-stack entries (≥2, power of two).
- RESET_VEC, 0, PC value after reset and after CLR.
- INT_VEC, 1, PC value loaded on INTR.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RST_N  input  1  asynchronous active-low reset.
- CLR  input  1  synchronous clear: PC to RESET_VEC, flush stack.
- INC  input  1  PC <= PC+1.
- SKIP  input  1  PC <= PC+2 (skip-next-instruction).
- LD  input  1  PC <= DATA.
- CALL  input  1  push PC+1, then PC <= DATA.
- RET  input  1  PC <= popped top of stack.
- INTR  input  1  push PC (unincremented), then PC <= INT_VEC.
- ERR_CLR  input  1  clears sticky STK_ERR.
- DATA  input  W  load/call target.
- Q  output  W  current PC (registered).
- SP  output  $clog2(DEPTH)+1  number of valid stack entries, 0..DEPTH.
- STK_EMPTY  output  1  SP==0 (combinational from SP).
- STK_FULL  output  1  SP==DEPTH (combinational from SP).
- STK_ERR  output  1  sticky overflow/underflow flag.

Behaviour:
- RST_N low (async): Q=RESET_VEC, SP=0, STK_ERR=0. Stack storage is not reset; its contents are don't-care while SP excludes them.
- One operation per cycle, chosen by fixed priority: CLR > INTR > RET > CALL > LD > SKIP > INC. Lower-priority strobes in the same cycle are ignored entirely, with no partial effects.
- No strobe asserted: Q and SP hold.
- Latency: every op takes effect at the next rising edge, so Q shows the new value one cycle after the strobe. Stack write and SP update happen on the same edge.
- Arithmetic: all PC math is modulo 2^W.
  - INC at 2^W-1 gives 0.
  - SKIP at 2^W-2 gives 0; SKIP at 2^W-1 gives 1.
  - CALL pushes (Q+1) mod 2^W.
- CLR: Q=RESET_VEC, SP=0, STK_ERR unchanged.
- CALL with SP<DEPTH: stack[SP]=Q+1, SP+1, Q=DATA.
- CALL with SP==DEPTH (overflow): Q=DATA still, no push, SP and existing entries unchanged, STK_ERR=1.
- INTR with SP<DEPTH: stack[SP]=Q, SP+1, Q=INT_VEC.
- INTR with SP==DEPTH (overflow): Q=INT_VEC still, no push, STK_ERR=1.
- RET with SP>0: Q=stack[SP-1], SP-1.
- RET with SP==0 (underflow): behaves as INC (Q+1), SP stays 0, STK_ERR=1.
- STK_ERR set/clear: ERR_CLR clears it on the next edge. If a set condition occurs in the same cycle as ERR_CLR, set wins and STK_ERR stays 1.
- Reset asserted mid-operation overrides everything immediately. After RST_N deasserts, the first edge behaves as a normal cycle.

Decomposition:
- Package pc_seq_pkg holds:
  - op enum: OP_NONE, OP_INC, OP_SKIP, OP_LD, OP_CALL, OP_RET, OP_INTR, OP_CLR;
  - priority-encode function from the strobe vector to op.
- Sub-module pc_ret_stack(W, DEPTH): LIFO with push/pop/flush inputs, SP/top/full/empty outputs. It ignores push when full and pop when empty.
- Top level decodes the op, computes next-Q, and owns STK_ERR.

Test Plan:
- Reset/INC: RST_N low then high, Q=0. INC for 5 cycles gives Q=5. Drive Q to 0xFFF, then INC gives Q=0x000, STK_ERR=0.
- Priority: Q=0x010, assert INC+LD+SKIP with DATA=0x2A0, giving Q=0x2A0 next cycle. Assert CLR+INTR giving Q=0, SP unchanged at 0.
- Nested call/return: Q=0x100, CALL DATA=0x200; at 0x200, CALL DATA=0x300, giving SP=2. RET gives Q=0x201, SP=1. RET gives Q=0x101, SP=0, STK_EMPTY=1.
- Overflow: four CALLs fill stack (SP=4, STK_FULL=1). Fifth CALL DATA=0x555 gives Q=0x555, SP=4, STK_ERR=1. Four RETs return the original four addresses in LIFO order.
- Underflow/ERR_CLR: SP=0, Q=0x07F, RET gives Q=0x080, STK_ERR=1. ERR_CLR alone gives STK_ERR=0. ERR_CLR together with underflow RET keeps STK_ERR=1.
- INTR and async reset: Q=0x0A5, INTR gives Q=0x001, stack top=0x0A5. RET gives Q=0x0A5. Pulse RST_N low between edges: Q=0 and SP=0 immediately, before the next CLK edge.
